// File: rtl/fme_pkg.sv
// Shared types and defaults for the fractional-ME best-candidate selector.
// Holds the FSM encoding, default widths and the saturating-add rule.
package fme_pkg;

    localparam int FME_SATD_W = 16;
    localparam int FME_ACC_W  = 20;
    localparam int FME_NCAND  = 9;
    localparam int FME_MV_W   = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_CMP   = 2'd2,
        ST_OUT   = 2'd3
    } fme_state_e;

    // Unsigned add clamped to 2^w-1; callers keep w <= 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/fme_cost_acc.sv
// Saturating candidate-cost accumulator; the first block of a candidate
// loads satd + mvcost, later blocks add satd. One-cycle update, no backpressure.
module fme_cost_acc
    import fme_pkg::*;
#(
    parameter int SATD_W = FME_SATD_W,
    parameter int ACC_W  = FME_ACC_W,
    parameter int MV_W   = FME_MV_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              first_i,
    input  logic [SATD_W-1:0] satd_i,
    input  logic [MV_W-1:0]   mvcost_i,
    output logic [ACC_W-1:0]  acc_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [31:0]      base;

    always_comb begin
        base  = first_i ? 32'(mvcost_i) : 32'(acc_q);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = ACC_W'(sat_add(base, 32'(satd_i), ACC_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fme_best_sel.sv
// Picks the lowest-cost candidate (SATD sum + MV cost) out of NCAND per search.
// Result valid two cycles after the last SATD handshake; held until done_rdy.
module fme_best_sel
    import fme_pkg::*;
#(
    parameter int SATD_W = FME_SATD_W,
    parameter int ACC_W  = FME_ACC_W,
    parameter int NCAND  = FME_NCAND
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        nblk,
    input  logic [SATD_W-1:0] satd_in,
    input  logic              satd_vld,
    output logic              satd_rdy,
    input  logic [11:0]       mvcost_in,
    output logic              busy,
    output logic [3:0]        best_idx,
    output logic [ACC_W-1:0]  best_cost,
    output logic              done_vld,
    input  logic              done_rdy
);

    fme_state_e       state_q;
    logic             arm_q;
    logic [3:0]       last_blk_q;
    logic [3:0]       blk_cnt_q;
    logic [3:0]       cand_q;
    logic [3:0]       best_idx_q;
    logic [ACC_W-1:0] best_cost_q;

    logic             start_ok;
    logic             hs;
    logic [3:0]       last_blk_d;
    logic [ACC_W-1:0] acc;

    // arm_q blocks a start on the very first edge after reset release.
    assign start_ok = start & arm_q & (state_q == ST_IDLE);
    assign hs       = satd_vld & (state_q == ST_ACCUM);

    always_comb begin
        last_blk_d = 4'd0;
        if (nblk > 5'd16) begin
            last_blk_d = 4'd15;
        end else if (nblk != 5'd0) begin
            last_blk_d = 4'(nblk - 5'd1);
        end
    end

    fme_cost_acc #(
        .SATD_W (SATD_W),
        .ACC_W  (ACC_W),
        .MV_W   (12)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (start_ok),
        .en_i     (hs),
        .first_i  (blk_cnt_q == 4'd0),
        .satd_i   (satd_in),
        .mvcost_i (mvcost_in),
        .acc_o    (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            arm_q       <= 1'b0;
            last_blk_q  <= '0;
            blk_cnt_q   <= '0;
            cand_q      <= '0;
            best_idx_q  <= '0;
            best_cost_q <= '0;
        end else begin
            arm_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        last_blk_q  <= last_blk_d;
                        blk_cnt_q   <= '0;
                        cand_q      <= '0;
                        best_idx_q  <= '0;
                        best_cost_q <= '1;
                        state_q     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (hs) begin
                        if (blk_cnt_q == last_blk_q) begin
                            blk_cnt_q <= '0;
                            state_q   <= ST_CMP;
                        end else begin
                            blk_cnt_q <= blk_cnt_q + 4'd1;
                        end
                    end
                end
                ST_CMP: begin
                    // Strict compare keeps the lower index on ties; candidate 0 seeds the best.
                    if ((acc < best_cost_q) || (cand_q == 4'd0)) begin
                        best_cost_q <= acc;
                        best_idx_q  <= cand_q;
                    end
                    if (cand_q == 4'(NCAND - 1)) begin
                        state_q <= ST_OUT;
                    end else begin
                        cand_q  <= cand_q + 4'd1;
                        state_q <= ST_ACCUM;
                    end
                end
                ST_OUT: begin
                    if (done_rdy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign satd_rdy  = (state_q == ST_ACCUM);
    assign busy      = (state_q != ST_IDLE);
    assign done_vld  = (state_q == ST_OUT);
    assign best_idx  = best_idx_q;
    assign best_cost = best_cost_q;

endmodule

// File: tb/tb_fme_best_sel.sv
// Directed bench for fme_best_sel: reference cost model plus per-cycle result checker.
module tb_fme_best_sel;

    localparam int MAXC = 1048575;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  nblk;
    logic [15:0] satd_in;
    logic        satd_vld;
    logic        satd_rdy;
    logic [11:0] mvcost_in;
    logic        busy;
    logic [3:0]  best_idx;
    logic [19:0] best_cost;
    logic        done_vld;
    logic        done_rdy;

    fme_best_sel dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .nblk      (nblk),
        .satd_in   (satd_in),
        .satd_vld  (satd_vld),
        .satd_rdy  (satd_rdy),
        .mvcost_in (mvcost_in),
        .busy      (busy),
        .best_idx  (best_idx),
        .best_cost (best_cost),
        .done_vld  (done_vld),
        .done_rdy  (done_rdy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int satd_tab [9][16];
    int mv_tab [9];
    int exp_idx, exp_cost;
    logic [31:0] got_idx, got_cost;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Reference: per-candidate total = mvcost + sum of SATDs clamped at MAXC, argmin, lowest index on ties.
    task automatic model(input int nb);
        int n, cost;
        n = (nb == 0) ? 1 : nb;
        for (int c = 0; c < 9; c++) begin
            cost = mv_tab[c];
            for (int b = 0; b < n; b++) cost += satd_tab[c][b];
            if (cost > MAXC) cost = MAXC;
            if (c == 0 || cost < exp_cost) begin
                exp_cost = cost;
                exp_idx  = c;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done_vld) begin
            chk("res_idx", 32'(best_idx), 32'(exp_idx));
            chk("res_cost", 32'(best_cost), 32'(exp_cost));
            chk("busy_in_out", 32'(busy), 32'd1);
            got_idx  = 32'(best_idx);
            got_cost = 32'(best_cost);
        end
    end

    task automatic do_start(input int nb);
        start = 1'b1;
        nblk  = 5'(nb);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Feeds all candidates in order; abort_after >= 0 stops after that many handshakes.
    task automatic feed(input int nb, input bit gaps, input int abort_after);
        int n, hs, t, k;
        n  = (nb == 0) ? 1 : nb;
        hs = 0;
        for (int c = 0; c < 9; c++) begin
            for (int b = 0; b < n; b++) begin
                if (abort_after >= 0 && hs == abort_after) return;
                if (gaps) begin
                    satd_vld = 1'b0;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                satd_vld  = 1'b1;
                satd_in   = 16'(satd_tab[c][b]);
                mvcost_in = 12'(mv_tab[c]);
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!satd_rdy && t < 50);
                if (!satd_rdy) begin
                    chk("satd_rdy_timeout", 32'(satd_rdy), 32'd1);
                    satd_vld = 1'b0;
                    return;
                end
                @(posedge clk); #1;
                hs++;
            end
        end
        satd_vld  = 1'b1;
        satd_in   = 16'd1;
        mvcost_in = 12'd0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done_vld && k < 20);
        chk("done_latency", 32'(k), 32'd2);
        @(posedge clk); #1;
        satd_vld = 1'b0;
    endtask

    task automatic finish_out(input int hold, input bit poke);
        done_rdy = 1'b0;
        start    = poke;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        done_rdy = 1'b1;
        start    = poke;
        @(posedge clk); #1;
        done_rdy = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done_vld", 32'(done_vld), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; nblk = 5'd0; satd_in = 16'd0;
        satd_vld = 1'b0; mvcost_in = 12'd0; done_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_satd_rdy", 32'(satd_rdy), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_vld", 32'(done_vld), 32'd0);
        chk("rst_best_idx", 32'(best_idx), 32'd0);
        chk("rst_best_cost", 32'(best_cost), 32'd0);

        // A: nblk=1, V-shaped SATDs, start held across the first two edges after release.
        for (int c = 0; c < 9; c++) begin
            satd_tab[c][0] = (c <= 4) ? 50 - 10 * c : 10 * c - 30;
            mv_tab[c] = 0;
        end
        model(1);
        chk("model_A_idx", 32'(exp_idx), 32'd4);
        chk("model_A_cost", 32'(exp_cost), 32'd10);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        nblk  = 5'd1;
        @(posedge clk); #1;
        chk("first_edge_start_ignored", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("second_edge_start_taken", 32'(busy), 32'd1);
        feed(1, 1'b0, -1);
        finish_out(0, 1'b0);
        chk("A_idx", got_idx, 32'd4);
        chk("A_cost", got_cost, 32'd10);

        // B: tie across candidates 1..8 keeps index 1.
        for (int c = 0; c < 9; c++) begin
            for (int b = 0; b < 4; b++) satd_tab[c][b] = 100;
            mv_tab[c] = (c == 0) ? 8 : 4;
        end
        model(4);
        do_start(4);
        feed(4, 1'b0, -1);
        finish_out(1, 1'b0);
        chk("B_idx", got_idx, 32'd1);
        chk("B_cost", got_cost, 32'd404);

        // C: every candidate saturates.
        for (int c = 0; c < 9; c++) begin
            for (int b = 0; b < 16; b++) satd_tab[c][b] = 65535;
            mv_tab[c] = 4095;
        end
        model(16);
        do_start(16);
        feed(16, 1'b0, -1);
        finish_out(0, 1'b0);
        chk("C_idx", got_idx, 32'd0);
        chk("C_cost", got_cost, 32'd1048575);

        // D: random vld gaps, start held high while busy, result held 5 cycles.
        for (int c = 0; c < 9; c++) begin
            for (int b = 0; b < 3; b++) satd_tab[c][b] = (c == 6) ? 5 : 100 + c;
            mv_tab[c] = 2;
        end
        model(3);
        do_start(3);
        start = 1'b1;
        feed(3, 1'b1, -1);
        finish_out(5, 1'b1);
        chk("D_idx", got_idx, 32'd6);
        chk("D_cost", got_cost, 32'd17);

        // E: reset during candidate 3, then a fresh search.
        for (int c = 0; c < 9; c++) begin
            for (int b = 0; b < 2; b++) satd_tab[c][b] = 100 - 5 * c;
            mv_tab[c] = 0;
        end
        model(2);
        do_start(2);
        feed(2, 1'b0, 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done_vld", 32'(done_vld), 32'd0);
        chk("midrst_satd_rdy", 32'(satd_rdy), 32'd0);
        chk("midrst_best_cost", 32'(best_cost), 32'd0);
        satd_vld = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start(2);
        feed(2, 1'b0, -1);
        finish_out(0, 1'b0);
        chk("E_idx", got_idx, 32'd8);
        chk("E_cost", got_cost, 32'd120);

        // F: nblk=0 acts as 1; vld asserted with junk while idle.
        for (int c = 0; c < 9; c++) begin
            satd_tab[c][0] = (c == 2) ? 5 : 30;
            mv_tab[c] = c;
        end
        model(0);
        satd_vld = 1'b1;
        satd_in  = 16'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_consume", 32'(busy), 32'd0);
        do_start(0);
        feed(0, 1'b0, -1);
        finish_out(0, 1'b0);
        chk("F_idx", got_idx, 32'd2);
        chk("F_cost", got_cost, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fme_best_sel.md
FME_BEST_SEL -- requirements
Module: fme_best_sel

Interface
REQ-001 SHALL have parameter SATD_W, default 16: width of one 4x4 SATD result.
REQ-002 SHALL have parameter ACC_W, default 20: width of the candidate cost accumulator.
REQ-003 SHALL have parameter NCAND, default 9: candidates per search (centre plus 8 neighbours).
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: one-cycle pulse that begins a search.
REQ-007 SHALL have port nblk, input, 5: 4x4 blocks per candidate (1..16), sampled on start.
REQ-008 SHALL have port satd_in, input, SATD_W: SATD of one 4x4 block from the SATD arbiter outputs.
REQ-009 SHALL have port satd_vld, input, 1: satd_in is valid.
REQ-010 SHALL have port satd_rdy, output, 1: block accepts satd_in.
REQ-011 SHALL have port mvcost_in, input, 12: motion-vector rate cost of the current candidate, sampled with that candidate's first SATD.
REQ-012 SHALL have port busy, output, 1: a search is in progress.
REQ-013 SHALL have port best_idx, output, 4: winning candidate index 0..NCAND-1.
REQ-014 SHALL have port best_cost, output, ACC_W: total cost of the winning candidate.
REQ-015 SHALL have port done_vld, output, 1: best_idx and best_cost are valid.
REQ-016 SHALL have port done_rdy, input, 1: consumer accepts the result.

Function
REQ-017 SHALL implement FSM IDLE, ACCUM, CMP, OUT.
REQ-018 IDLE: on start, SHALL latch nblk, clear acc, block counter, candidate counter and best_cost (to all ones), then go to ACCUM; nblk=0 SHALL be treated as 1.
REQ-019 ACCUM: satd_rdy SHALL be 1; a handshake (satd_vld & satd_rdy) SHALL add satd_in to acc and increment the block counter.
REQ-020 The first handshake of a candidate SHALL load acc with satd_in + mvcost_in, ignoring the previous value.
REQ-021 All additions SHALL saturate at 2^ACC_W-1.
REQ-022 The handshake with block counter = nblk-1 SHALL move the FSM to CMP.
REQ-023 CMP: satd_rdy SHALL be 0 for exactly one cycle.
REQ-024 CMP: if acc < best_cost, best_cost SHALL take acc and best_idx SHALL take the candidate counter.
REQ-025 Ties SHALL keep the lower index; candidate 0 always wins against the all-ones initial value.
REQ-026 CMP: if candidate = NCAND-1, the next state SHALL be OUT; otherwise the candidate counter SHALL increment and the next state SHALL be ACCUM.
REQ-027 OUT: done_vld SHALL be 1 and best_idx/best_cost SHALL be held stable until done_rdy; on the done_rdy cycle the FSM SHALL return to IDLE.
REQ-028 Latency SHALL be done_vld = 1 exactly two cycles after the final SATD handshake, when no stall occurs.
REQ-029 busy SHALL be 1 in ACCUM, CMP and OUT; start while busy SHALL be ignored.
REQ-030 satd_vld SHALL be ignored in IDLE, CMP and OUT; no data is consumed.
REQ-031 In OUT, start arriving in the same cycle as done_rdy SHALL be ignored.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, including mid-search, and discard any partial search.
REQ-033 rst_n low SHALL force satd_rdy=0, busy=0, done_vld=0, best_idx=0, best_cost=0, and all counters and acc to 0.
REQ-034 The first start SHALL be accepted on the second rising edge after rst_n deasserts.

Structure
REQ-035 The state encoding, SATD_W/ACC_W/NCAND defaults and the saturating-add width rule SHALL live in shared package fme_pkg.
REQ-036 The saturating accumulator with its first-block load SHALL be sub-module fme_cost_acc; the FSM, counters and compare SHALL live in fme_best_sel.

Verification
REQ-037 Bench SHALL cover: nblk=1, nine SATDs 50,40,30,20,10,20,30,40,50, mvcost=0 -> best_idx=4, best_cost=10, done_vld two cycles after the ninth handshake.
REQ-038 Bench SHALL cover: nblk=4, all SATDs 100, mvcost 8,4,4,4,4,4,4,4,4 -> best_idx=1 (tie keeps lower), best_cost=404.
REQ-039 Bench SHALL cover: nblk=16, all SATDs 65535, mvcost=4095 -> every cost saturates at 1048575, best_idx=0.
REQ-040 Bench SHALL cover: random satd_vld gaps plus done_rdy held low for 5 cycles -> results unchanged, outputs stable, start ignored during OUT.
REQ-041 Bench SHALL cover: rst_n pulsed low during candidate 3 -> busy=0 and done_vld=0 immediately; a fresh search then gives correct results.
REQ-042 Bench SHALL cover: nblk=0 -> behaves as nblk=1, with nine handshakes per search.
